control_unit_state: RTL and testbench
=====================================

CONTROL_UNIT_STATE -- requirements
Module: control_unit_state

Interface
REQ-001 SHALL provide port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL provide port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide port: run  input  1  1 = execute instructions; 0 = stop at next instruction boundary.
REQ-004 SHALL provide port: instr_ready  input  1  instruction memory has valid data this cycle.
REQ-005 SHALL provide port: opcode  input  6  IR[31:26], valid from the cycle after IR capture.
REQ-006 SHALL provide port: curState  output  4  registered state code, consumed by the control-signal decoder.
REQ-007 SHALL provide port: illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-008 SHALL provide port: instr_retired  output  32  retired-instruction count (REQ-028).
REQ-009 SHALL provide port: cycle_count  output  32  cycles spent outside idle (REQ-028).

Function
REQ-010 SHALL use the fixed state codes: idle 0000, fetch 0001, decode 0010, memAddress 0011, memRead 0100, memWriteBack 0101, memWrite 0110, execute 0111, ALUWriteBack 1000, branch 1001, addiExecute 1010, addiWriteBack 1011, jump 1100, suspend 1101.
REQ-011 SHALL register curState; next-state logic combinational; one transition per clk edge.
REQ-012 idle: SHALL go to fetch when run=1, else stay idle.
REQ-013 fetch: SHALL go to decode if instr_ready=1, else to suspend.
REQ-014 suspend: SHALL stay while instr_ready=0; go to decode when instr_ready=1.
REQ-015 decode: SHALL latch opcode into an internal op register and branch on it: 100011 (lw) or 101011 (sw) -> memAddress; 000000 (R-type) -> execute; 000100 (beq) -> branch; 001000 (addi) -> addiExecute; 000010 (j) -> jump.
REQ-016 decode with any other opcode: SHALL pulse illegal_op for exactly one cycle (the cycle after decode) and proceed as a retired no-op boundary (REQ-020).
REQ-017 memAddress: SHALL go to memRead if latched op = lw, memWrite if sw.
REQ-018 memRead -> memWriteBack; execute -> ALUWriteBack; addiExecute -> addiWriteBack; each unconditional.
REQ-019 Terminal states memWriteBack, memWrite, ALUWriteBack, branch, addiWriteBack, jump, and illegal decode, SHALL be instruction boundaries.
REQ-020 At a boundary: SHALL go to fetch if run=1, else idle.
REQ-021 run deassertion mid-instruction SHALL NOT abort it; the instruction completes and stops at the boundary.
REQ-022 Latency per instruction excluding suspend cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
REQ-023 Unused codes 1110/1111 SHALL transition to idle on the next edge without illegal_op.
REQ-024 opcode SHALL be sampled only in decode; changes in other states SHALL have no effect.

Reset
REQ-025 rst_n=0 at a clk edge SHALL force curState=idle, illegal_op=0, op register=000000, instr_retired=0, cycle_count=0, regardless of current state.
REQ-026 Reset mid-instruction SHALL discard the instruction with no retire count; rst_n SHALL NOT act asynchronously.
REQ-027 After rst_n returns to 1, first fetch SHALL occur on the first edge with run=1.

Configuration
REQ-028 Macro CU_PERF_CNT_EN: defined -> instr_retired increments by 1 at each boundary (illegal included), cycle_count increments every cycle curState != idle, both wrap modulo 2^32; undefined -> both outputs tied to 0 and no counter flops built.

Verification
REQ-029 Reset, run=1, instr_ready=1, opcode=100011 -> curState 0001,0010,0011,0100,0101,0001; instr_retired=1 after memWriteBack (macro on).
REQ-030 fetch with instr_ready=0 for 3 cycles -> curState 0001,1101,1101,1101,0010; cycle_count grows by 5 over those cycles.
REQ-031 opcode=000100 then 000010 -> 0010,1001,0001,0010,1100,0001.
REQ-032 opcode=111111 in decode -> illegal_op=1 for one cycle, next state 0001, instr_retired +1.
REQ-033 run dropped during execute (opcode 000000) -> 0111,1000,0000; stays 0000 until run=1.
REQ-034 rst_n=0 during memRead -> next edge curState=0000, counters 0, illegal_op 0; macro off -> counters read 0 throughout.

Source files
------------

// File: rtl/control_unit_state.sv
// Multi-cycle control FSM that steps through fetch, decode and the per-opcode execute states.
// Define CU_PERF_CNT_EN to build the retired-instruction and busy-cycle counters.
module control_unit_state (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        instr_ready,
  input  logic [5:0]  opcode,
  output logic [3:0]  curState,
  output logic        illegal_op,
  output logic [31:0] instr_retired,
  output logic [31:0] cycle_count
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'b0000,
    S_FETCH     = 4'b0001,
    S_DECODE    = 4'b0010,
    S_MEM_ADDR  = 4'b0011,
    S_MEM_READ  = 4'b0100,
    S_MEM_WB    = 4'b0101,
    S_MEM_WRITE = 4'b0110,
    S_EXECUTE   = 4'b0111,
    S_ALU_WB    = 4'b1000,
    S_BRANCH    = 4'b1001,
    S_ADDI_EXEC = 4'b1010,
    S_ADDI_WB   = 4'b1011,
    S_JUMP      = 4'b1100,
    S_SUSPEND   = 4'b1101
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       boundary;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    boundary  = 1'b0;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH:     state_d = instr_ready ? S_DECODE : S_SUSPEND;
      S_SUSPEND:   if (instr_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            // Unsupported opcode retires as a no-op and ends the instruction here.
            illegal_d = 1'b1;
            boundary  = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP:
        boundary = 1'b1;
      default:     state_d = S_IDLE;
    endcase
    // run is only consulted at instruction boundaries, so dropping it never aborts an instruction.
    if (boundary) state_d = run ? S_FETCH : S_IDLE;
  end

  // NOTE: state flops use non-blocking assignments; reset sits inside the clocked branch so it
  // only takes effect on a rising clk edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 6'b000000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  assign curState   = state_q;
  assign illegal_op = illegal_q;

`ifdef CU_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    retired_d = retired_q + {31'b0, boundary};
    cycles_d  = cycles_q + {31'b0, state_q != S_IDLE};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
      cycles_q  <= 32'd0;
    end else begin
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

  assign instr_retired = retired_q;
  assign cycle_count   = cycles_q;
`else
  assign instr_retired = 32'd0;
  assign cycle_count   = 32'd0;
`endif

endmodule

// File: tb/tb_control_unit_state.sv
// Self-checking bench for control_unit_state: directed traces plus randomized instruction streams
// checked against an instruction-level model (state path, illegal pulse, retire and busy counts).
module tb_control_unit_state;

  localparam logic [3:0] IDLE = 4'd0,  FETCH = 4'd1,  DECODE = 4'd2, MADDR = 4'd3,
                         MREAD = 4'd4, MWB = 4'd5,    MWRITE = 4'd6, EXEC = 4'd7,
                         ALUWB = 4'd8, BRANCH = 4'd9, AEXEC = 4'd10, AWB = 4'd11,
                         JUMP = 4'd12, SUSP = 4'd13;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;
`ifdef CU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, run, instr_ready;
  logic [5:0]  opcode;
  logic [3:0]  curState;
  logic        illegal_op;
  logic [31:0] instr_retired, cycle_count;
  int          vectors = 0;
  int          errors  = 0;

  control_unit_state dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .curState      (curState),
    .illegal_op    (illegal_op),
    .instr_retired (instr_retired),
    .cycle_count   (cycle_count)
  );

  always #5 clk = ~clk;

  // Instruction-level view: states visited after decode, per opcode (empty = illegal).
  function automatic int path_len(input logic [5:0] op);
    case (op)
      LW:          return 3;
      SW, RT, ADDI: return 2;
      BEQ, JMP:    return 1;
      default:     return 0;
    endcase
  endfunction

  function automatic logic [3:0] path_state(input logic [5:0] op, input int i);
    case (op)
      LW:      return (i == 0) ? MADDR : (i == 1) ? MREAD : MWB;
      SW:      return (i == 0) ? MADDR : MWRITE;
      RT:      return (i == 0) ? EXEC : ALUWB;
      ADDI:    return (i == 0) ? AEXEC : AWB;
      BEQ:     return BRANCH;
      JMP:     return JUMP;
      default: return IDLE;
    endcase
  endfunction

  // Drive one cycle of inputs, take the edge, and settle just after it.
  task automatic step(input logic r, input logic rdy, input logic [5:0] opc);
    run = r;
    instr_ready = rdy;
    opcode = opc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b1, BAD);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, BAD);
      vectors++;
      if (curState !== IDLE || illegal_op !== 1'b0 || instr_retired !== 32'd0 || cycle_count !== 32'd0) begin
        errors++;
        $display("FAIL reset[%0d]: state=%b ill=%b ret=%0d cyc=%0d expected 0000/0/0/0",
                 i, curState, illegal_op, instr_retired, cycle_count);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, LW);
      vectors++;
      if (curState !== IDLE) begin
        errors++;
        $display("FAIL idle_hold[%0d]: state=%b expected %b", i, curState, IDLE);
      end
    end
    step(1'b1, 1'b0, BAD);
    vectors++;
    if (curState !== FETCH || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL first_fetch: state=%b cyc=%0d expected %b/0", curState, cycle_count, FETCH);
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp [6];
    logic [5:0] opc [6];
    exp = '{FETCH, DECODE, MADDR, MREAD, MWB, FETCH};
    opc = '{BAD, BAD, LW, BAD, BAD, BAD};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, opc[i]);
      vectors++;
      if (curState !== exp[i]) begin
        errors++;
        $display("FAIL lw[%0d]: state=%b expected %b", i, curState, exp[i]);
      end
    end
    vectors++;
    if (instr_retired !== (PERF ? 32'd1 : 32'd0) || cycle_count !== (PERF ? 32'd5 : 32'd0)) begin
      errors++;
      $display("FAIL lw_counters: ret=%0d cyc=%0d expected %0d/%0d",
               instr_retired, cycle_count, PERF ? 1 : 0, PERF ? 5 : 0);
    end
  endtask

  task automatic test_suspend();
    logic [3:0] exp [8];
    logic       rdy [8];
    logic [5:0] opc [8];
    exp = '{FETCH, SUSP, SUSP, SUSP, DECODE, EXEC, ALUWB, FETCH};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    opc = '{BAD, RT, RT, RT, BAD, RT, LW, LW};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, rdy[i], opc[i]);
      vectors++;
      if (curState !== exp[i]) begin
        errors++;
        $display("FAIL suspend[%0d]: state=%b expected %b", i, curState, exp[i]);
      end
      if (i == 5) begin
        vectors++;
        if (cycle_count !== (PERF ? 32'd5 : 32'd0)) begin
          errors++;
          $display("FAIL suspend_cycles: cyc=%0d expected %0d", cycle_count, PERF ? 5 : 0);
        end
      end
    end
  endtask

  task automatic test_beq_j();
    logic [3:0] exp [7];
    logic [5:0] opc [7];
    exp = '{FETCH, DECODE, BRANCH, FETCH, DECODE, JUMP, FETCH};
    opc = '{BAD, BAD, BEQ, LW, BAD, JMP, SW};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, opc[i]);
      vectors++;
      if (curState !== exp[i]) begin
        errors++;
        $display("FAIL beq_j[%0d]: state=%b expected %b", i, curState, exp[i]);
      end
    end
    vectors++;
    if (instr_retired !== (PERF ? 32'd2 : 32'd0)) begin
      errors++;
      $display("FAIL beq_j_retired: ret=%0d expected %0d", instr_retired, PERF ? 2 : 0);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    step(1'b1, 1'b1, BAD);
    step(1'b1, 1'b1, BAD);
    vectors++;
    if (curState !== DECODE || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pre: state=%b ill=%b expected %b/0", curState, illegal_op, DECODE);
    end
    step(1'b1, 1'b1, BAD);
    vectors++;
    if (curState !== FETCH || illegal_op !== 1'b1 || instr_retired !== (PERF ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL illegal_pulse: state=%b ill=%b ret=%0d expected %b/1/%0d",
               curState, illegal_op, instr_retired, FETCH, PERF ? 1 : 0);
    end
    step(1'b1, 1'b1, BAD);
    vectors++;
    if (curState !== DECODE || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: state=%b ill=%b expected %b/0", curState, illegal_op, DECODE);
    end
  endtask

  task automatic test_run_drop();
    logic [3:0] exp [9];
    logic       r   [9];
    exp = '{FETCH, DECODE, EXEC, ALUWB, IDLE, IDLE, IDLE, IDLE, FETCH};
    r   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(r[i], 1'b1, (i == 2) ? RT : BAD);
      vectors++;
      if (curState !== exp[i]) begin
        errors++;
        $display("FAIL run_drop[%0d]: state=%b expected %b", i, curState, exp[i]);
      end
    end
    vectors++;
    if (instr_retired !== (PERF ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL run_drop_retired: ret=%0d expected %0d", instr_retired, PERF ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 1'b1, BAD);
    step(1'b1, 1'b1, BAD);
    step(1'b1, 1'b1, LW);
    step(1'b1, 1'b1, BAD);
    rst_n = 1'b0;
    #2;
    vectors++;
    if (curState !== MREAD) begin
      errors++;
      $display("FAIL reset_sync: state=%b expected %b before edge", curState, MREAD);
    end
    step(1'b1, 1'b1, BAD);
    vectors++;
    if (curState !== IDLE || illegal_op !== 1'b0 || instr_retired !== 32'd0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: state=%b ill=%b ret=%0d cyc=%0d expected 0000/0/0/0",
               curState, illegal_op, instr_retired, cycle_count);
    end
    rst_n = 1'b1;
    step(1'b1, 1'b1, BAD);
    step(1'b1, 1'b1, BAD);
    rst_n = 1'b0;
    step(1'b1, 1'b1, BAD);
    vectors++;
    if (curState !== IDLE || illegal_op !== 1'b0 || instr_retired !== 32'd0) begin
      errors++;
      $display("FAIL reset_on_illegal: state=%b ill=%b ret=%0d expected 0000/0/0",
               curState, illegal_op, instr_retired);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0]  legal [6];
    logic [5:0]  op, opc;
    logic [3:0]  exp_s;
    logic        rv, r, rdy, ill, exp_ill;
    logic [31:0] m_retired, m_cycles;
    int          k, plen, nsteps, wait_n;
    legal = '{LW, SW, RT, BEQ, ADDI, JMP};
    do_reset();
    m_retired = 32'd0;
    m_cycles  = 32'd0;
    step(1'b1, 1'b1, BAD);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do op = 6'($urandom); while (path_len(op) != 0);
      end else begin
        op = legal[$urandom_range(0, 5)];
      end
      plen   = path_len(op);
      ill    = (plen == 0);
      k      = $urandom_range(0, 3);
      rv     = ($urandom_range(0, 3) != 0);
      nsteps = k + 1 + (ill ? 1 : plen + 1);
      for (int s = 0; s < nsteps; s++) begin
        r = 1'($urandom);
        rdy = 1'($urandom);
        opc = 6'($urandom);
        exp_ill = 1'b0;
        if (s < k) begin
          rdy = 1'b0;
          exp_s = SUSP;
        end else if (s == k) begin
          rdy = 1'b1;
          exp_s = DECODE;
        end else if (s == k + 1) begin
          opc = op;
          if (ill) begin
            r = rv;
            exp_s = rv ? FETCH : IDLE;
            exp_ill = 1'b1;
          end else begin
            exp_s = path_state(op, 0);
          end
        end else if (s < nsteps - 1) begin
          exp_s = path_state(op, s - k - 1);
        end else begin
          r = rv;
          exp_s = rv ? FETCH : IDLE;
        end
        step(r, rdy, opc);
        m_cycles = m_cycles + 32'd1;
        if (s == nsteps - 1) m_retired = m_retired + 32'd1;
        vectors++;
        if (curState !== exp_s || illegal_op !== exp_ill) begin
          errors++;
          $display("FAIL rand[%0d.%0d] op=%b: state=%b ill=%b expected %b/%b",
                   n, s, op, curState, illegal_op, exp_s, exp_ill);
        end
        vectors++;
        if (instr_retired !== (PERF ? m_retired : 32'd0) || cycle_count !== (PERF ? m_cycles : 32'd0)) begin
          errors++;
          $display("FAIL rand_cnt[%0d.%0d]: ret=%0d cyc=%0d expected %0d/%0d", n, s,
                   instr_retired, cycle_count, PERF ? m_retired : 0, PERF ? m_cycles : 0);
        end
      end
      if (!rv) begin
        wait_n = $urandom_range(1, 3);
        for (int j = 0; j <= wait_n; j++) begin
          step(j == wait_n, 1'($urandom), 6'($urandom));
          vectors++;
          if (curState !== ((j == wait_n) ? FETCH : IDLE) || cycle_count !== (PERF ? m_cycles : 32'd0)) begin
            errors++;
            $display("FAIL rand_idle[%0d.%0d]: state=%b cyc=%0d", n, j, curState, cycle_count);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    instr_ready = 1'b0;
    opcode = 6'b000000;
    test_reset();
    test_lw();
    test_suspend();
    test_beq_j();
    test_illegal();
    test_run_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
